// File: rtl/mux_sel_pipe_pkg.sv
// Shared constants for the operand-select pipeline stage: default widths,
// forwarding-unit select codes and the skid buffer occupancy states.
package mux_sel_pipe_pkg;

    localparam int XLEN          = 64;
    localparam int DEF_ERR_CNT_W = 16;

    // Operand-select codes driven by the forwarding unit
    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_sel_pipe_skid_reg.sv
// Two-entry valid/ready skid buffer: main output register plus one skid slot.
// in_ready is registered and equals "skid slot empty".
module skid_reg
    import mux_sel_pipe_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_emit;

    assign w_accept  = in_valid & r_in_ready;
    assign w_emit    = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_data  = r_main;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_emit) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the emit side can move
                    if (w_emit) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-to-1 operand selector feeding a registered valid/ready skid stage, with
// out-of-range select flagging and a saturating select-error counter.
module mux_sel_pipe
    import mux_sel_pipe_pkg::*;
#(
    parameter  int WIDTH     = XLEN,
    parameter  int NUM_IN    = 3,
    parameter  int ERR_CNT_W = DEF_ERR_CNT_W,
    localparam int SEL_W     = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic [ERR_CNT_W-1:0]    err_count
);

    logic [WIDTH-1:0]     w_sel_data;
    logic                 w_sel_err;
    logic [WIDTH:0]       w_skid_out;
    logic                 w_accept;
    logic [ERR_CNT_W-1:0] r_err_count;

    // Every select code resolves: unmatched codes give zero data with err set
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(in_sel) == k) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
                w_sel_err  = 1'b0;
            end
        end
    end

    skid_reg #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({w_sel_err, w_sel_data}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_skid_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data  = w_skid_out[WIDTH-1:0];
    assign out_err   = w_skid_out[WIDTH];
    assign w_accept  = in_valid & in_ready;
    assign err_count = r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_sel_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed-vector bench for mux_sel_pipe (NUM_IN=3, WIDTH=64, 4-bit error counter).
module tb_mux_sel_pipe;
    import mux_sel_pipe_pkg::*;

    localparam int WIDTH     = 64;
    localparam int NUM_IN    = 3;
    localparam int ERR_CNT_W = 4;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_clr;
    logic [ERR_CNT_W-1:0]    err_count;

    int n_tests;
    int n_fail;

    mux_sel_pipe #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] stream_sel [4];
    logic [63:0] stream_exp [4];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_data   = {64'h3, 64'h2, 64'h1};
        in_sel    = SEL_REG;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        tick();
        tick();
        rst = 1'b0;

        // First transfer: one-cycle latency
        in_sel   = SEL_EXMEM;
        in_valid = 1'b1;
        tick();
        chk("first_data",  out_data,       64'h2);
        chk("first_err",   64'(out_err),   64'd0);
        chk("first_valid", 64'(out_valid), 64'd1);

        // Streaming with out_ready held high
        stream_sel[0] = SEL_REG;   stream_exp[0] = 64'h1;
        stream_sel[1] = SEL_EXMEM; stream_exp[1] = 64'h2;
        stream_sel[2] = SEL_MEMWB; stream_exp[2] = 64'h3;
        stream_sel[3] = SEL_REG;   stream_exp[3] = 64'h1;
        for (int i = 0; i < 4; i++) begin
            in_sel = stream_sel[i];
            tick();
            chk($sformatf("stream_data%0d", i), out_data, stream_exp[i]);
            chk($sformatf("stream_rdy%0d", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: fill main then skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = SEL_REG;
        tick();
        chk("bp_one_data",  out_data,      64'h1);
        chk("bp_one_rdy",   64'(in_ready), 64'd1);
        in_sel = SEL_MEMWB;
        tick();
        chk("bp_two_rdy",   64'(in_ready), 64'd0);
        chk("bp_two_data",  out_data,      64'h1);
        // Offered while full: must be ignored
        in_sel = SEL_EXMEM;
        tick();
        chk("bp_hold_data",  out_data,       64'h1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_rdy",   64'(in_ready),  64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_second_data", out_data,       64'h3);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_rdy_back",    64'(in_ready),  64'd1);
        tick();
        chk("bp_empty_valid", 64'(out_valid), 64'd0);

        // Out-of-range select
        in_valid = 1'b1;
        in_sel   = 2'd3;
        tick();
        chk("oor_data",  out_data,        64'd0);
        chk("oor_err",   64'(out_err),    64'd1);
        chk("oor_count", 64'(err_count),  64'd1);
        err_clr = 1'b1;
        tick();
        chk("oor_clr_wins", 64'(err_count), 64'd0);
        chk("oor_err2",     64'(out_err),   64'd1);
        err_clr = 1'b0;

        // Valid in-range item clears out_err and leaves the counter alone
        in_sel = SEL_MEMWB;
        tick();
        chk("inrange_err",   64'(out_err),   64'd0);
        chk("inrange_data",  out_data,       64'h3);
        chk("inrange_count", 64'(err_count), 64'd0);

        // Saturation of the 4-bit counter
        in_sel = 2'd3;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count", 64'(err_count), 64'd15);
        in_valid = 1'b0;
        err_clr  = 1'b1;
        tick();
        chk("sat_clr", 64'(err_count), 64'd0);
        err_clr = 1'b0;
        tick();

        // Reset while both entries are occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = SEL_REG;
        tick();
        in_sel = SEL_EXMEM;
        tick();
        chk("mid_two_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #4 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_rdy",   64'(in_ready),  64'd1);
        chk("mid_rst_data",  out_data,       64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = SEL_MEMWB;
        tick();
        chk("post_rst_data",  out_data,       64'h3);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
Parametrised N-to-1 data selector with a registered, flow-controlled output stage. It generalises the pipeline's 3:1 operand mux to arbitrary width and input count. It adds a valid/ready handshake with a skid buffer and defined out-of-range select behaviour, so no latch can be inferred. It sits between the forwarding/operand-select logic and the execute-stage input register.

Parameters:
WIDTH, 64, data width of each input and of the output
NUM_IN, 3, number of data inputs (2..16)
SEL_W, $clog2(NUM_IN), select width (derived localparam, not overridable)
ERR_CNT_W, 16, width of the saturating select-error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  index of the input to forward
in_valid  input  1  upstream presents data/sel this cycle
in_ready  output  1  block accepts this cycle (registered)
out_data  output  WIDTH  selected data
out_err  output  1  out_data resulted from an out-of-range select
out_valid  output  1  out_data/out_err valid
out_ready  input  1  downstream accepts this cycle
err_clr  input  1  synchronous clear of err_count
err_count  output  ERR_CNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Reset is asynchronous and active-high; one clock domain. While rst=1: out_valid=0, out_data=0, out_err=0, in_ready=1 (asserted from the reset value), skid buffer empty, err_count=0.
- Accept: a transfer occurs when in_valid & in_ready at a rising edge. Emit: a transfer occurs when out_valid & out_ready.
- Selection: if in_sel < NUM_IN, the selected value is in_data[in_sel*WIDTH +: WIDTH] and err=0. Otherwise the selected value is all-zero and err=1. Every select code is covered.
- Latency: one cycle. Data accepted at edge t appears on out_data with out_valid=1 after edge t.
- Storage: main register plus one skid register, forming a 2-entry FIFO.
  - in_ready = skid empty, registered.
  - If the main register is full, out_ready=0 and an accept occurs, the accepted item goes to the skid register and in_ready drops at the next edge.
  - When the main register is emitted, the skid content (if any) moves into main on the same edge and in_ready rises.
- States: EMPTY (out_valid=0), ONE (main full, skid empty), TWO (both full, in_ready=0).
  - EMPTY + accept -> ONE.
  - ONE + accept without emit -> TWO.
  - ONE + emit without accept -> EMPTY.
  - ONE + accept + emit -> ONE, with the new item in main.
  - TWO + emit -> ONE.
  - No accept is possible in TWO.
- Ordering: strict FIFO. No item is dropped or duplicated under any out_ready pattern.
- out_data/out_err hold stable while out_valid=1 and out_ready=0.
- err_count increments by 1 on each accepted item with err=1 and saturates at 2^ERR_CNT_W-1.
  - err_clr=1 forces 0 on the next edge.
  - err_clr together with an error accept yields 0; clear wins.
- in_data/in_sel are ignored when no accept occurs. The select is evaluated only at accept.
- Reset asserted mid-transfer discards both entries immediately, with no partial output.

Decomposition:
- Shared header/package holds the default WIDTH (XLEN=64), the operand-select codes used by the forwarding unit (SEL_REG=0, SEL_EXMEM=1, SEL_MEMWB=2), and ERR_CNT_W.
- One sub-module: skid_reg (parametrised WIDTH+1 two-entry valid/ready skid buffer). The top instantiates it after a purely combinational select function.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1, err_count=0 before the next edge. Release, then in_data={C=64'h3,B=64'h2,A=64'h1}, sel=1, valid=1, out_ready=1 -> the next cycle shows out_data=64'h2, out_err=0, out_valid=1.
- Streaming: sel=0,1,2,0 on consecutive cycles with out_ready=1 -> out_data 1,2,3,1 each one cycle later; in_ready stays 1 throughout.
- Backpressure: out_ready=0 and push sel=0 then sel=2 -> in_ready falls after the second accept and out_data holds 64'h1. Raise out_ready -> outputs 1 then 3 in order, and in_ready returns to 1.
- Out-of-range: NUM_IN=3, sel=3 accepted -> out_data=0, out_err=1, err_count=1. Pulse err_clr together with another sel=3 accept -> err_count=0.
- Saturation: ERR_CNT_W=4 and 20 accepted sel=3 items -> err_count=15.
- Reset mid-operation: fill to TWO with out_ready=0, then assert rst -> out_valid=0 immediately. After release, the first output is only new data; the earlier items never appear.
